// File: rtl/uplink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uplink_pkg
// Purpose  : Shared types and constants for the uplink TX arbiter.
//            Optional source tag byte: UPLINK_SRC_TAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
package uplink_pkg;

`ifdef UPLINK_SRC_TAG_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TAG   = 3'd1,
        ST_FETCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;
`endif

    localparam logic [1:0] SRC_FREQ   = 2'd0;
    localparam logic [1:0] SRC_ADDA   = 2'd1;
    localparam logic [1:0] SRC_LOGIC  = 2'd2;
    localparam logic [1:0] GRANT_NONE = 2'd3;
    localparam logic [7:0] TAG_BASE   = 8'hF0;

    // Next source index in the 0 -> 1 -> 2 -> 0 ring; an out-of-range
    // value wraps to source 0.
    function automatic logic [1:0] rr_next(input logic [1:0] x);
        return (x >= SRC_LOGIC) ? SRC_FREQ : (x + 2'd1);
    endfunction

endpackage : uplink_pkg
`default_nettype wire

// File: rtl/uplink_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : uplink_rr_pick
// Purpose  : Combinational 3-way round-robin picker. The search starts at
//            the source after 'last' and wraps around the ring.
// Revision : 1.0 - initial release
// ============================================================================
module uplink_rr_pick
    import uplink_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] w_c0;
    logic [1:0] w_c1;
    logic [1:0] w_c2;

    // Walk the ring starting one past the previous owner; first requester wins.
    always_comb begin
        w_c0 = rr_next(last);
        w_c1 = rr_next(w_c0);
        w_c2 = rr_next(w_c1);
        any  = |req;
        idx  = w_c0;
        if (req[w_c0]) begin
            idx = w_c0;
        end else if (req[w_c1]) begin
            idx = w_c1;
        end else if (req[w_c2]) begin
            idx = w_c2;
        end
    end

endmodule : uplink_rr_pick
`default_nettype wire

// File: rtl/uplink_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uplink_tx_arbiter
// Purpose  : Packet-level round-robin arbiter sharing the UART uplink between
//            the frequency meter, AD/DA capture and logic analyser. Locks onto
//            one source for a whole packet and feeds the byte transmitter one
//            byte at a time, honouring its done pulse. A stalled packet is
//            dropped after TIMEOUT_CYC idle FETCH cycles.
//            Optional macro UPLINK_SRC_TAG_EN: prefix each packet with a tag
//            byte 8'hF0 | grant.
// Revision : 1.0 - initial release
// ============================================================================
module uplink_tx_arbiter
    import uplink_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  src_en,
    input  logic [2:0]  src_valid,
    input  logic [23:0] src_data,
    input  logic [2:0]  src_last,
    output logic [2:0]  src_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        abort
);

    localparam int                 c_cnt_w   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT_CYC);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_grant;
    logic [1:0]         r_last_grant;
    logic [7:0]         r_tx_data;
    logic               r_last;
    logic               r_abort;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_inc;

    logic [2:0]         w_cand;
    logic [1:0]         w_pick_idx;
    logic               w_pick_any;
    logic [7:0]         w_sel_data;
    logic [2:0]         w_src_ready;
    logic               w_tx_start;
    logic               w_xfer;
    logic               w_timeout;
    logic               w_to_idle;

    // Enables only matter while choosing the next packet owner.
    assign w_cand    = src_valid & src_en;
    assign w_cnt_inc = r_cnt + c_cnt_w'(1);

    uplink_rr_pick u_pick (
        .req  (w_cand),
        .last (r_last_grant),
        .idx  (w_pick_idx),
        .any  (w_pick_any)
    );

    // Byte lane of the current owner.
    always_comb begin
        case (r_grant)
            SRC_FREQ:  w_sel_data = src_data[7:0];
            SRC_ADDA:  w_sel_data = src_data[15:8];
            SRC_LOGIC: w_sel_data = src_data[23:16];
            default:   w_sel_data = 8'h00;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        w_next      = r_state;
        w_src_ready = 3'b000;
        w_tx_start  = 1'b0;
        w_xfer      = 1'b0;
        w_timeout   = 1'b0;
        w_to_idle   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
`ifdef UPLINK_SRC_TAG_EN
                    w_next = ST_TAG;
`else
                    w_next = ST_FETCH;
`endif
                end
            end
`ifdef UPLINK_SRC_TAG_EN
            ST_TAG: begin
                w_tx_start = 1'b1;
                w_next     = ST_WAIT;
            end
`endif
            ST_FETCH: begin
                w_src_ready = 3'b001 << r_grant;
                w_xfer      = |(src_valid & w_src_ready);
                if (w_xfer) begin
                    w_next = ST_SEND;
                end else if (w_cnt_inc == c_timeout) begin
                    w_timeout = 1'b1;
                    w_to_idle = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_SEND: begin
                w_tx_start = 1'b1;
                w_next     = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (r_last) begin
                        w_to_idle = 1'b1;
                        w_next    = ST_IDLE;
                    end else begin
                        w_next = ST_FETCH;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Grant bookkeeping, byte capture and abort pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant      <= GRANT_NONE;
            r_last_grant <= SRC_LOGIC;
            r_tx_data    <= 8'h00;
            r_last       <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_abort <= w_timeout;
            if (r_state == ST_IDLE && w_pick_any) begin
                r_grant <= w_pick_idx;
`ifdef UPLINK_SRC_TAG_EN
                r_tx_data <= TAG_BASE | {6'b000000, w_pick_idx};
                r_last    <= 1'b0;
`endif
            end
            if (w_xfer) begin
                r_tx_data <= w_sel_data;
                r_last    <= src_last[r_grant];
            end
            if (w_to_idle) begin
                r_last_grant <= r_grant;
                r_grant      <= GRANT_NONE;
            end
        end
    end

    // Stall counter: restarts on each entry to FETCH, counts idle FETCH cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_next == ST_FETCH && r_state != ST_FETCH) begin
            r_cnt <= '0;
        end else if (r_state == ST_FETCH && !w_xfer) begin
            r_cnt <= w_cnt_inc;
        end
    end

    assign src_ready = w_src_ready;
    assign tx_start  = w_tx_start;
    assign tx_data   = r_tx_data;
    assign grant     = r_grant;
    assign busy      = (r_state != ST_IDLE);
    assign abort     = r_abort;

endmodule : uplink_tx_arbiter
`default_nettype wire
